// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- built-in self-test initiator for one sram instance.
// Runs the sequence up(wZ) up(rZ,wO) up(rO,wZ) down(rZ,wO) down(rO,wZ) down(rZ)
// over all N = 2**ADDR_WIDTH words and reports the result.
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   start                            1-cycle request, honoured only in IDLE
//   busy, done, pass                 run status; done is a 1-cycle end pulse
//   err_cnt                          saturating miscompare count
//   fail_addr/fail_data/fail_exp     capture of the first miscompare
//   mem_wr/mem_rd/mem_addr/mem_din   registered sram controls
//   mem_dout                         sram read data
module sram_march_bist #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int unsigned WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [DATA_WIDTH-1:0] PAT_ZERO  = '0;
  localparam logic [DATA_WIDTH-1:0] PAT_ONE   = '1;
  localparam logic [2:0]            ELEM_LAST = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_ISSUE, S_RD_WAIT, S_DONE
  } state_t;

  state_t                state_q, state_n;
  logic [2:0]            elem_q, elem_n;    // current March element E0..E5
  logic                  step_q, step_n;    // 0: first op of element, 1: trailing write
  logic [WCW-1:0]        wait_q, wait_n;
  logic                  busy_n, done_n, pass_n, wr_n, rd_n;
  logic [7:0]            err_n;
  logic [ADDR_WIDTH-1:0] faddr_n, addr_n;
  logic [DATA_WIDTH-1:0] fdata_n, fexp_n, din_n;

  logic                  advance;
  logic                  down;
  logic                  last_addr;
  logic [2:0]            elem_inc;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [DATA_WIDTH-1:0] wr_word;

  // Element decode: direction, expected read word and written word
  always_comb begin
    down      = (elem_q >= 3'd3);
    last_addr = down ? (mem_addr == '0) : (mem_addr == ADDR_MAX);
    elem_inc  = 3'(elem_q + 3'd1);
    exp_word  = (elem_q == 3'd2 || elem_q == 3'd4) ? PAT_ONE : PAT_ZERO;
    wr_word   = (elem_q == 3'd1 || elem_q == 3'd3) ? PAT_ONE : PAT_ZERO;
  end

  // Next-state and registered-output values
  always_comb begin
    state_n = state_q;
    elem_n  = elem_q;
    step_n  = step_q;
    wait_n  = wait_q;
    pass_n  = pass;
    err_n   = err_cnt;
    faddr_n = fail_addr;
    fdata_n = fail_data;
    fexp_n  = fail_exp;
    addr_n  = mem_addr;
    din_n   = mem_din;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_n  = 1'b0;
          err_n   = '0;
          faddr_n = '0;
          fdata_n = '0;
          fexp_n  = '0;
          elem_n  = '0;
          step_n  = 1'b0;
          addr_n  = '0;
          din_n   = PAT_ZERO;
          state_n = S_WRITE;
        end
      end
      S_WRITE: advance = 1'b1;
      S_RD_ISSUE: begin
        wait_n  = '0;
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (wait_q == WCW'(RD_LAT - 1)) begin
          advance = 1'b1;
          if (mem_dout != exp_word) begin
            if (err_cnt != 8'hFF) err_n = 8'(err_cnt + 8'd1);
            if (err_cnt == 8'd0) begin
              faddr_n = mem_addr;
              fdata_n = mem_dout;
              fexp_n  = exp_word;
            end
            if (STOP_ON_FAIL != 0) advance = 1'b0;
            if (STOP_ON_FAIL != 0) state_n = S_DONE;
          end
        end else begin
          wait_n = WCW'(wait_q + 1'b1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Pick the next operation once the current one has completed
    if (advance) begin
      if (elem_q != 3'd0 && elem_q != ELEM_LAST && !step_q) begin
        step_n  = 1'b1;
        din_n   = wr_word;
        state_n = S_WRITE;
      end else if (last_addr) begin
        if (elem_q == ELEM_LAST) begin
          state_n = S_DONE;
        end else begin
          elem_n  = elem_inc;
          step_n  = 1'b0;
          addr_n  = (elem_inc >= 3'd3) ? ADDR_MAX : '0;
          state_n = S_RD_ISSUE;
        end
      end else begin
        step_n = 1'b0;
        addr_n = down ? ADDR_WIDTH'(mem_addr - 1'b1) : ADDR_WIDTH'(mem_addr + 1'b1);
        if (elem_q == 3'd0) begin
          din_n   = PAT_ZERO;
          state_n = S_WRITE;
        end else begin
          state_n = S_RD_ISSUE;
        end
      end
    end

    wr_n   = (state_n == S_WRITE);
    rd_n   = (state_n == S_RD_ISSUE);
    busy_n = (state_n == S_WRITE) || (state_n == S_RD_ISSUE) || (state_n == S_RD_WAIT);
    done_n = (state_n == S_DONE);
    if (state_n == S_DONE) pass_n = (err_n == 8'd0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      elem_q    <= '0;
      step_q    <= 1'b0;
      wait_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_exp  <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      state_q   <= state_n;
      elem_q    <= elem_n;
      step_q    <= step_n;
      wait_q    <= wait_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_cnt   <= err_n;
      fail_addr <= faddr_n;
      fail_data <= fdata_n;
      fail_exp  <= fexp_n;
      mem_wr    <= wr_n;
      mem_rd    <= rd_n;
      mem_addr  <= addr_n;
      mem_din   <= din_n;
    end
  end

endmodule
